ring_fifo: RTL and testbench
============================

Name: ring_fifo

Overview:
Parametrised successor to the 32-bit single-mode ring buffer. It adds configurable data width and depth, full DEPTH-entry capacity, and a selectable overwrite or reject policy on full. It also provides empty/full/almost-full flags, underflow detection, a saturating drop counter and a synchronous flush. It sits between producers and consumers in the CPU/IO path, for example UART receive data feeding the core.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 512, number of storage entries (>=2; need not be a power of two)
OVERWRITE, 1, 1 = write on full drops the oldest entry; 0 = write on full is rejected
AFULL_TH, DEPTH-4, almost_full asserts when count >= AFULL_TH
DROP_W, 16, width of the drop counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of buffer state
we  in  1  write request
wd  in  WIDTH  write data
re  in  1  read/pop request
rd  out  WIDTH  head entry (show-ahead)
count  out  $clog2(DEPTH+1)  number of stored entries
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_TH
overflow  out  1  sticky: a write hit a full buffer
underflow  out  1  one-cycle pulse: re while empty
drop_count  out  DROP_W  saturating count of dropped or rejected words

Behaviour:
- Clock and reset: one clock domain. reset is synchronous and active-high and is sampled on the posedge of clock.
- Reset values: head=0, tail=0, count=0, overflow=0, underflow=0, drop_count=0. Therefore empty=1, full=0, almost_full=0.
- Memory: storage is not reset. rd is undefined while empty.
- Read data: rd = mem[head], combinational from the registered head pointer (zero read latency).
- Write latency: a written word appears on rd on the next cycle if the buffer was empty. There is no same-cycle write-to-read bypass.
- Pointer advance: head and tail advance by explicit compare: ptr == DEPTH-1 -> 0, else ptr+1. No modulo.
- count register: maintained explicitly, so all DEPTH entries are usable.
- Priority: reset > flush > we/re.
- flush: clears head, tail, count and overflow. It does not clear drop_count. A we/re in the same cycle is ignored. underflow=0 that cycle.
- Per-cycle cases, not full and not empty:
  - we only: store at tail, tail++, count++.
  - re only: head++, count--, overflow<=0.
  - we & re: store, tail++, head++, count unchanged, overflow<=0.
- Empty:
  - re only: no state change, underflow=1 for that cycle.
  - we & re: the write is performed (count=1) and the read is ignored; underflow=1.
- Full, we & re: both performed, count stays DEPTH, no drop, overflow<=0.
- Full, we only, OVERWRITE=1: store at tail, tail++, head++ (oldest lost), count stays DEPTH, overflow<=1, drop_count++.
- Full, we only, OVERWRITE=0: no memory write, pointers unchanged, overflow<=1, drop_count++.
- Overflow clearing: overflow clears only on an accepted read (re while not empty) with no drop in the same cycle, or on flush/reset.
- drop_count: saturates at all-ones and never wraps.
- Flags: empty, full and almost_full are combinational from count.
- Non-power-of-two DEPTH: wrap is correct because of the explicit compare (e.g. DEPTH=5 wraps 4->0).

Test Plan:
1. DEPTH=4, OVERWRITE=1: write 1,2,3,4 -> full=1, count=4, rd=1. Write 5 (no re) -> count=4, rd=2, overflow=1, drop_count=1. Read 4 times -> rd sequence 2,3,4,5, overflow=0 after the first read, empty=1 at end.
2. DEPTH=4, OVERWRITE=0: write 1..5 -> count=4, overflow=1, drop_count=1. Read 4 times -> 1,2,3,4 (the 5 was rejected).
3. Empty buffer: pulse re -> underflow=1 for exactly 1 cycle, count=0. Then we=re=1 with wd=0xA -> count=1, rd=0xA next cycle, underflow=1 on that cycle.
4. Full buffer, we=re=1 for 10 cycles with incrementing data -> count stays 4, full=1, overflow=0, drop_count unchanged, output order preserved.
5. DEPTH=5, AFULL_TH=3: 12 writes interleaved with reads across two wraps -> FIFO order preserved. almost_full rises when count reaches 3 and falls when it drops to 2.
6. Mid-operation: count=3, overflow=1, drop_count=2, then flush with we=1 -> next cycle count=0, empty=1, overflow=0, drop_count=2. Assert reset -> drop_count=0 and all flags at their reset values.

Source files
------------

// File: rtl/ring_fifo.sv
// ---------------------------------------------------------------------------
// ring_fifo
//
// Parametrised single-clock ring buffer sitting between producers and
// consumers in the CPU/IO path (e.g. UART receive data feeding the core).
// All DEPTH entries are usable because occupancy is held in an explicit
// count register rather than derived from the pointers. On a write to a
// full buffer the OVERWRITE parameter selects between dropping the oldest
// entry (1) and rejecting the new word (0).
//
// Parameters:
//   WIDTH      data word width in bits
//   DEPTH      number of storage entries (>= 2, any value, not just 2^n)
//   OVERWRITE  1 = write on full drops oldest, 0 = write on full rejected
//   AFULL_TH   almost_full asserts when count >= AFULL_TH
//   DROP_W     width of the saturating drop counter
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   flush        synchronous clear of pointers, count and overflow
//   we / wd      write request and write data
//   re           read (pop) request
//   rd           head entry, show-ahead; undefined while empty
//   count        number of stored entries
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AFULL_TH
//   overflow     sticky: a write hit a full buffer
//   underflow    single-cycle pulse: re while empty
//   drop_count   saturating count of dropped or rejected words
// ---------------------------------------------------------------------------
module ring_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 512,
    parameter int OVERWRITE = 1,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int DROP_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         we,
    input  logic [WIDTH-1:0]             wd,
    input  logic                         re,
    output logic [WIDTH-1:0]             rd,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow,
    output logic [DROP_W-1:0]            drop_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam bit OW = (OVERWRITE != 0);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_drop;
    logic w_push;
    logic w_pop;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A read is accepted only when there is something to pop. On a full
    // buffer a simultaneous read makes room, so only a lone write drops.
    assign w_rd_ok = re && !w_empty;
    assign w_drop  = we && w_full && !re;

    // In overwrite mode a dropping write still stores and also retires the
    // oldest entry, so it acts as a push plus a pop.
    assign w_push  = we && (!w_full || re || OW);
    assign w_pop   = w_rd_ok || (w_drop && OW);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (flush) begin
            // drop_count deliberately survives a flush.
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // A dropping write never coincides with an accepted read, so
            // the set and clear conditions are mutually exclusive.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_rd_ok) begin
                r_overflow <= 1'b0;
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable
    // behind a valid count, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (w_push && !reset && !flush) begin
            r_mem[r_tail] <= wd;
        end
    end

    assign rd          = r_mem[r_head];
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (int'(r_count) >= AFULL_TH);
    assign overflow    = r_overflow;
    assign drop_count  = r_drop;
    // Reset and flush override any request, so no pulse in those cycles.
    assign underflow   = re && w_empty && !reset && !flush;

endmodule

// File: tb/tb_ring_fifo.sv
// ---------------------------------------------------------------------------
// tb_ring_fifo
//
// Four ring_fifo instances, exercised one at a time:
//   0: DEPTH=4, OVERWRITE=1, AFULL_TH=3
//   1: DEPTH=4, OVERWRITE=0, AFULL_TH=3
//   2: DEPTH=5, OVERWRITE=1, AFULL_TH=3
//   3: DEPTH=3, OVERWRITE=0, AFULL_TH=2
// A queue model tracks the active instance; expected words are pushed when
// written and popped/compared when the instance delivers them on rd.
// ---------------------------------------------------------------------------
module tb_ring_fifo;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        flush_a [N];
    logic        we_a    [N];
    logic        re_a    [N];
    logic [31:0] wd_a    [N];
    logic [31:0] rd_a    [N];
    logic [2:0]  count_a [N];
    logic        empty_a [N];
    logic        full_a  [N];
    logic        af_a    [N];
    logic        ovf_a   [N];
    logic        unf_a   [N];
    logic [15:0] drop_a  [N];
    logic [1:0]  count_d3;

    int depth_c [N] = '{4, 4, 5, 3};
    int ow_c    [N] = '{1, 0, 1, 0};
    int af_c    [N] = '{3, 3, 3, 2};

    int          cur;
    logic [31:0] q[$];
    bit          m_ovf;
    int          m_drop;
    int          n_asrt = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    assign count_a[3] = {1'b0, count_d3};

    ring_fifo #(.WIDTH(32), .DEPTH(4), .OVERWRITE(1), .AFULL_TH(3), .DROP_W(16)) u_ow (
        .clock(clock), .reset(reset), .flush(flush_a[0]), .we(we_a[0]), .wd(wd_a[0]),
        .re(re_a[0]), .rd(rd_a[0]), .count(count_a[0]), .empty(empty_a[0]),
        .full(full_a[0]), .almost_full(af_a[0]), .overflow(ovf_a[0]),
        .underflow(unf_a[0]), .drop_count(drop_a[0])
    );

    ring_fifo #(.WIDTH(32), .DEPTH(4), .OVERWRITE(0), .AFULL_TH(3), .DROP_W(16)) u_rj (
        .clock(clock), .reset(reset), .flush(flush_a[1]), .we(we_a[1]), .wd(wd_a[1]),
        .re(re_a[1]), .rd(rd_a[1]), .count(count_a[1]), .empty(empty_a[1]),
        .full(full_a[1]), .almost_full(af_a[1]), .overflow(ovf_a[1]),
        .underflow(unf_a[1]), .drop_count(drop_a[1])
    );

    ring_fifo #(.WIDTH(32), .DEPTH(5), .OVERWRITE(1), .AFULL_TH(3), .DROP_W(16)) u_d5 (
        .clock(clock), .reset(reset), .flush(flush_a[2]), .we(we_a[2]), .wd(wd_a[2]),
        .re(re_a[2]), .rd(rd_a[2]), .count(count_a[2]), .empty(empty_a[2]),
        .full(full_a[2]), .almost_full(af_a[2]), .overflow(ovf_a[2]),
        .underflow(unf_a[2]), .drop_count(drop_a[2])
    );

    ring_fifo #(.WIDTH(32), .DEPTH(3), .OVERWRITE(0), .AFULL_TH(2), .DROP_W(16)) u_d3 (
        .clock(clock), .reset(reset), .flush(flush_a[3]), .we(we_a[3]), .wd(wd_a[3]),
        .re(re_a[3]), .rd(rd_a[3]), .count(count_d3), .empty(empty_a[3]),
        .full(full_a[3]), .almost_full(af_a[3]), .overflow(ovf_a[3]),
        .underflow(unf_a[3]), .drop_count(drop_a[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL dut%0d %s: observed %0h expected %0h", cur, tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = q.size();
        check({tag, ".count"}, 32'(count_a[cur]), 32'(sz));
        check({tag, ".empty"}, 32'(empty_a[cur]), 32'(sz == 0));
        check({tag, ".full"},  32'(full_a[cur]),  32'(sz == depth_c[cur]));
        check({tag, ".afull"}, 32'(af_a[cur]),    32'(sz >= af_c[cur]));
        check({tag, ".ovf"},   32'(ovf_a[cur]),   32'(m_ovf));
        check({tag, ".drop"},  32'(drop_a[cur]),  32'(m_drop));
        if (sz != 0) begin
            check({tag, ".head"}, rd_a[cur], q[0]);
        end
    endtask

    // Called just after a rising edge: drive one cycle of requests, check the
    // combinational outputs mid-cycle, then update the model and check state.
    task automatic step(input bit w, input bit r, input logic [31:0] d, input bit f = 1'b0);
        bit was_full;
        we_a[cur]    = w;
        re_a[cur]    = r;
        wd_a[cur]    = d;
        flush_a[cur] = f;
        @(negedge clock);
        check("underflow", 32'(unf_a[cur]), 32'(r && !f && (q.size() == 0)));
        if (r && !f && (q.size() != 0)) begin
            check("sb_pop", rd_a[cur], q[0]);
        end
        @(posedge clock);
        #1;
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (q.size() == depth_c[cur]);
            if (r && (q.size() != 0)) begin
                void'(q.pop_front());
                m_ovf = 1'b0;
            end
            if (w) begin
                if (!was_full || r) begin
                    q.push_back(d);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                    if (ow_c[cur] != 0) begin
                        void'(q.pop_front());
                        q.push_back(d);
                    end
                end
            end
        end
        we_a[cur]    = 1'b0;
        re_a[cur]    = 1'b0;
        flush_a[cur] = 1'b0;
        check_state("step");
    endtask

    task automatic select_dut(input int k);
        cur    = k;
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            select_dut(k);
            check_state("reset");
            check("reset.underflow", 32'(unf_a[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v;
        for (int k = 0; k < N; k++) begin
            flush_a[k] = 1'b0;
            we_a[k]    = 1'b0;
            re_a[k]    = 1'b0;
            wd_a[k]    = '0;
        end
        cur = 0;
        do_reset();

        // Overwrite mode: fill, overwrite the oldest, drain.
        select_dut(0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b1, 1'b0, 32'd5);
        repeat (4) step(1'b0, 1'b1, 32'd0);

        // Underflow on empty, then simultaneous write/read on empty.
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'hA);
        step(1'b0, 1'b1, 32'd0);

        // Full buffer with concurrent write and read for ten cycles.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(10 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'(20 + i));
        repeat (4) step(1'b0, 1'b1, 32'd0);

        // Reject mode: the fifth word never enters.
        select_dut(1);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i));
        repeat (4) step(1'b0, 1'b1, 32'd0);

        // DEPTH=5: interleaved phases, twelve writes, two full wraps.
        select_dut(2);
        v = 100;
        repeat (4) begin step(1'b1, 1'b0, 32'(v)); v++; end
        repeat (3) step(1'b0, 1'b1, 32'd0);
        repeat (4) begin step(1'b1, 1'b0, 32'(v)); v++; end
        repeat (4) step(1'b0, 1'b1, 32'd0);
        repeat (4) begin step(1'b1, 1'b0, 32'(v)); v++; end
        repeat (5) step(1'b0, 1'b1, 32'd0);

        // DEPTH=3 reject: count=3, overflow=1, drop=2, then flush with we=1.
        select_dut(3);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b1, 1'b0, 32'd99, 1'b1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
